// File: rtl/cdc_handshake_sync.sv
// Two-phase (toggle) req/ack multi-bit CDC channel, clk -> d_clk, one word in flight.
// Optional destination backpressure: define CDC_HS_DST_READY_EN to add dst_ready and a FULL state.
`timescale 1ns/1ps

module cdc_handshake_sync #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_clk,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] src_data,
  output logic             dst_valid,
  output logic [WIDTH-1:0] dst_data
`ifdef CDC_HS_DST_READY_EN
  ,
  input  logic             dst_ready
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} src_state_t;

  src_state_t             r_src_state;
  logic                   r_src_ready;
  logic                   r_req_t;
  logic [WIDTH-1:0]       r_src_hold;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack_sync;

  logic [SYNC_STAGES-1:0] r_req_sync;
  logic                   w_req_sync;
  logic                   r_req_seen;
  logic                   r_ack_t;
  logic                   r_dst_valid;
  logic [WIDTH-1:0]       r_dst_data;

  assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];
  assign w_req_sync = r_req_sync[SYNC_STAGES-1];
  assign src_ready  = r_src_ready;
  assign dst_valid  = r_dst_valid;
  assign dst_data   = r_dst_data;

  // Source FSM: src_hold stays frozen from the req toggle until the matching ack returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src_state <= S_IDLE;
      r_src_ready <= 1'b1;
      r_req_t     <= 1'b0;
      r_src_hold  <= '0;
    end else begin
      case (r_src_state)
        S_IDLE: begin
          if (src_valid && r_src_ready) begin
            r_src_hold  <= src_data;
            r_req_t     <= ~r_req_t;
            r_src_ready <= 1'b0;
            r_src_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_ack_sync == r_req_t) begin
            r_src_ready <= 1'b1;
            r_src_state <= S_IDLE;
          end
        end
        default: begin
          r_src_ready <= 1'b1;
          r_src_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ack_sync <= '0;
    else      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], r_ack_t};
  end

  always_ff @(posedge d_clk or negedge rst) begin
    if (!rst) r_req_sync <= '0;
    else      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], r_req_t};
  end

`ifdef CDC_HS_DST_READY_EN
  typedef enum logic {D_EMPTY, D_FULL} dst_state_t;
  dst_state_t r_dst_state;

  // Ack is withheld until the word is consumed, so the source stalls end to end.
  always_ff @(posedge d_clk or negedge rst) begin
    if (!rst) begin
      r_dst_state <= D_EMPTY;
      r_req_seen  <= 1'b0;
      r_ack_t     <= 1'b0;
      r_dst_valid <= 1'b0;
      r_dst_data  <= '0;
    end else begin
      case (r_dst_state)
        D_EMPTY: begin
          if (w_req_sync != r_req_seen) begin
            r_dst_data  <= r_src_hold;
            r_req_seen  <= w_req_sync;
            r_dst_valid <= 1'b1;
            r_dst_state <= D_FULL;
          end
        end
        D_FULL: begin
          if (r_dst_valid && dst_ready) begin
            r_dst_valid <= 1'b0;
            r_ack_t     <= r_req_seen;
            r_dst_state <= D_EMPTY;
          end
        end
        default: begin
          r_dst_valid <= 1'b0;
          r_dst_state <= D_EMPTY;
        end
      endcase
    end
  end
`else
  always_ff @(posedge d_clk or negedge rst) begin
    if (!rst) begin
      r_req_seen  <= 1'b0;
      r_ack_t     <= 1'b0;
      r_dst_valid <= 1'b0;
      r_dst_data  <= '0;
    end else begin
      r_dst_valid <= 1'b0;
      if (w_req_sync != r_req_seen) begin
        r_dst_data  <= r_src_hold;
        r_req_seen  <= w_req_sync;
        r_ack_t     <= w_req_sync;
        r_dst_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdc_handshake_sync.sv
// Scoreboard bench for cdc_handshake_sync: words pushed at source transfer, popped at delivery.
`timescale 1ns/1ps

module tb_cdc_handshake_sync;

  logic       clk = 1'b0;
  logic       d_clk = 1'b0;
  logic       rst = 1'b0;
  logic       src_valid = 1'b0;
  logic       src_ready;
  logic [3:0] src_data = '0;
  logic       dst_valid;
  logic [3:0] dst_data;
`ifdef CDC_HS_DST_READY_EN
  logic       dst_ready = 1'b1;
`endif

  real d_half = 9.0;

  int n_cmp = 0;
  int n_err = 0;
  int tx_count = 0;
  int rx_count = 0;
  logic [3:0] sb_q[$];

  cdc_handshake_sync #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .d_clk     (d_clk),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .dst_valid (dst_valid),
    .dst_data  (dst_data)
`ifdef CDC_HS_DST_READY_EN
    ,
    .dst_ready (dst_ready)
`endif
  );

  always #10 clk = ~clk;
  initial forever #(d_half) d_clk = ~d_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && src_valid && src_ready) begin
      sb_q.push_back(src_data);
      tx_count++;
    end
  end

  always @(negedge d_clk) begin
    logic take;
    logic [3:0] exp;
    take = rst && dst_valid;
`ifdef CDC_HS_DST_READY_EN
    take = take && dst_ready;
`endif
    if (take) begin
      rx_count++;
      if (sb_q.size() == 0) check("rx_unexpected_word", 32'd1, 32'd0);
      else begin
        exp = sb_q.pop_front();
        check("rx_data", {28'b0, dst_data}, {28'b0, exp});
      end
    end
  end

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !src_ready) && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (10) @(posedge clk);
    check(tag, sb_q.size(), 0);
  endtask

  task automatic send_one(input logic [3:0] d);
    bit x;
    int n;
    x = 1'b0;
    n = 0;
    @(posedge clk); #2;
    src_valid = 1'b1;
    src_data  = d;
    while (!x && n < 200) begin
      @(negedge clk);
      x = src_valid && src_ready;
      @(posedge clk);
      n++;
    end
    #2 src_valid = 1'b0;
    check("send_accept", x, 1'b1);
  endtask

  task automatic run_stream(input int cycles, input bit gaps);
    bit x;
    int gap;
    logic [3:0] d;
    x = 1'b0;
    gap = 0;
    d = 4'h0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #2;
      if (x) begin
        d++;
        if (gaps) gap = $urandom_range(0, 10);
      end
      if (gap > 0) begin
        src_valid = 1'b0;
        gap--;
      end else src_valid = 1'b1;
      src_data = d;
      @(negedge clk);
      x = src_valid && src_ready;
    end
    @(posedge clk); #2;
    src_valid = 1'b0;
  endtask

  initial begin
    int n;
    int rx0;
    bit bad;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_src_ready", src_ready, 1'b1);
    check("reset_dst_valid", dst_valid, 1'b0);
    check("reset_dst_data", dst_data, 4'h0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (100) @(posedge clk);
    check("idle_no_dst_valid", rx_count, 0);

    // Single word with forward latency measurement
    @(posedge clk); #2;
    src_valid = 1'b1;
    src_data  = 4'hA;
    @(negedge clk);
    check("single_ready_before", src_ready, 1'b1);
    @(posedge clk);
    fork
      begin #2 src_valid = 1'b0; end
    join_none
    n = 0;
    while (!dst_valid && n < 20) begin
      @(posedge d_clk); #1;
      n++;
    end
    check("fwd_latency_3pm1", (n >= 2 && n <= 4), 1'b1);
    @(negedge clk);
    check("single_ready_dropped", src_ready, 1'b0);
    wait_drain("single_drain");
    repeat (30) @(posedge clk);
    check("single_rx_count", rx_count, 1);

    // Back-to-back and random gaps against both receiver clocks
    for (int k = 0; k < 2; k++) begin
      d_half = (k == 0) ? 9.0 : 11.0;
      repeat (5) @(posedge clk);
      run_stream(1000, 1'b0);
      wait_drain("b2b_drain");
      check("b2b_counts", rx_count, tx_count);
      run_stream(1000, 1'b1);
      wait_drain("gaps_drain");
      check("gaps_counts", rx_count, tx_count);
    end
    d_half = 9.0;

`ifdef CDC_HS_DST_READY_EN
    // Backpressure hold then release
    rx0 = rx_count;
    @(posedge d_clk); #1 dst_ready = 1'b0;
    send_one(4'h5);
    @(posedge clk); #2;
    src_valid = 1'b1;
    src_data  = 4'h6;
    n = 0;
    while (!dst_valid && n < 50) begin
      @(negedge d_clk);
      n++;
    end
    check("bp_word_arrived", dst_valid, 1'b1);
    bad = 1'b0;
    repeat (50) begin
      @(negedge d_clk);
      if (!(dst_valid && dst_data == 4'h5 && !src_ready)) bad = 1'b1;
    end
    check("bp_hold_stable", bad, 1'b0);
    @(posedge d_clk); #1 dst_ready = 1'b1;
    n = 0;
    bad = 1'b0;
    while (!bad && n < 200) begin
      @(negedge clk);
      bad = src_valid && src_ready;
      n++;
    end
    @(posedge clk); #2 src_valid = 1'b0;
    check("bp_next_accepted", bad, 1'b1);
    wait_drain("bp_drain");
    check("bp_rx_two", rx_count - rx0, 2);
`endif

    // Reset in WAIT discards the in-flight word
    @(posedge clk); #2;
    src_valid = 1'b1;
    src_data  = 4'h9;
    @(posedge clk); #1;
    src_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_src_ready", src_ready, 1'b1);
    check("midrst_dst_valid", dst_valid, 1'b0);
    check("midrst_dst_data", dst_data, 4'h0);
    tx_count = tx_count - sb_q.size();
    sb_q.delete();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    rx0 = rx_count;
    repeat (5) @(posedge clk);
    send_one(4'h3);
    wait_drain("midrst_drain");
    repeat (20) @(posedge clk);
    check("midrst_rx_once", rx_count - rx0, 1);

    check("final_counts", rx_count, tx_count);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
